// File: rtl/simon_pkg.sv
// rtl/simon_pkg.sv - shared constants, player state type and element helper for the Simon round
// Contents:
//   NIBBLE_W, MAX_LEN, SEQ_W  element width, maximum sequence length, packed sequence width
//   Q1..Q4                    one-hot colour codes for the four lights
//   player_state_t            playback FSM states
//   get_element()             selects element idx from a packed sequence
package simon_pkg;

  localparam int NIBBLE_W = 4;
  localparam int MAX_LEN  = 10;
  localparam int SEQ_W    = NIBBLE_W * MAX_LEN;

  localparam logic [NIBBLE_W-1:0] Q1 = 4'b0001;
  localparam logic [NIBBLE_W-1:0] Q2 = 4'b0010;
  localparam logic [NIBBLE_W-1:0] Q3 = 4'b0100;
  localparam logic [NIBBLE_W-1:0] Q4 = 4'b1000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ON   = 2'd1,
    OFF  = 2'd2,
    DONE = 2'd3
  } player_state_t;

  // Mux rather than a variable part-select so an index past MAX_LEN-1
  // yields dark instead of reading beyond the packed vector.
  function automatic logic [NIBBLE_W-1:0] get_element(input logic [SEQ_W-1:0] s,
                                                      input logic [3:0]       idx);
    logic [NIBBLE_W-1:0] r;
    r = '0;
    for (int k = 0; k < MAX_LEN; k++) begin
      if (idx == 4'(k)) r = s[k*NIBBLE_W +: NIBBLE_W];
    end
    return r;
  endfunction

endpackage

// File: rtl/interval_timer.sv
// rtl/interval_timer.sv - reloadable interval counter with a single expiry pulse
// Ports:
//   clock   in   rising-edge clock
//   resetn  in   asynchronous active-low reset
//   load    in   restart the count from zero on the next edge
//   length  in   interval length in cycles (>= 1)
//   expire  out  high for one cycle when the count reaches length-1
module interval_timer #(
  parameter int CNT_W = 2
) (
  input  logic         clock,
  input  logic         resetn,
  input  logic         load,
  input  logic [CNT_W:0] length,
  output logic         expire
);

  logic [CNT_W-1:0] count_q;
  logic             fired_q;
  logic             at_end;

  assign at_end = ({1'b0, count_q} == (length - (CNT_W+1)'(1)));
  // The count parks at length-1 instead of wrapping; fired_q keeps expire
  // from repeating until the next load.
  assign expire = at_end && !fired_q;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      count_q <= '0;
      fired_q <= 1'b0;
    end else if (load) begin
      count_q <= '0;
      fired_q <= 1'b0;
    end else if (at_end) begin
      fired_q <= 1'b1;
    end else begin
      count_q <= count_q + CNT_W'(1);
    end
  end

endmodule

// File: rtl/sequence_player.sv
// rtl/sequence_player.sv - plays a stored Simon colour sequence on the four lights
// Optional feature macro: SEQ_PLAYER_SPEEDUP_EN (halves on/off intervals when size >= 6)
// Ports:
//   CLOCK_50       in   system clock
//   resetn         in   asynchronous active-low reset
//   start          in   begin playback (sampled in IDLE only)
//   abort          in   synchronous cancel, returns to IDLE
//   sequenceSize   in   number of elements to play, 1..MAX_LEN
//   sequence_bits  in   packed one-hot elements, element k at [4k+3:4k]
//   lights         out  registered colour output, 0000 = dark
//   startreading   out  high during ON/OFF so the input checker stays parked
//   busy           out  high in any state but IDLE
//   done           out  one-cycle pulse at end of playback
module sequence_player
  import simon_pkg::*;
#(
  parameter int ON_CYCLES  = 25000000,
  parameter int OFF_CYCLES = 12500000
) (
  input  logic             CLOCK_50,
  input  logic             resetn,
  input  logic             start,
  input  logic             abort,
  input  logic [3:0]       sequenceSize,
  input  logic [SEQ_W-1:0] sequence_bits,
  output logic [3:0]       lights,
  output logic             startreading,
  output logic             busy,
  output logic             done
);

  localparam int MAX_CYC = (ON_CYCLES > OFF_CYCLES) ? ON_CYCLES : OFF_CYCLES;
  localparam int CNT_W   = ($clog2(MAX_CYC) < 1) ? 1 : $clog2(MAX_CYC);
  localparam int LEN_W   = CNT_W + 1;
  localparam int ON_HALF  = ((ON_CYCLES  >> 1) < 1) ? 1 : (ON_CYCLES  >> 1);
  localparam int OFF_HALF = ((OFF_CYCLES >> 1) < 1) ? 1 : (OFF_CYCLES >> 1);

  localparam logic [LEN_W-1:0] ON_LEN   = LEN_W'(ON_CYCLES);
  localparam logic [LEN_W-1:0] OFF_LEN  = LEN_W'(OFF_CYCLES);
  localparam logic [LEN_W-1:0] ON_FAST  = LEN_W'(ON_HALF);
  localparam logic [LEN_W-1:0] OFF_FAST = LEN_W'(OFF_HALF);

  player_state_t    state_q, state_d;
  logic [SEQ_W-1:0] seq_q, seq_d;
  logic [3:0]       size_q, size_d;
  logic [3:0]       index_q, index_d;
  logic [3:0]       lights_q, lights_d;
  logic             timer_load;
  logic             expire;
  logic             fast;
  logic             size_ok;
  logic [LEN_W-1:0] timer_len;

`ifdef SEQ_PLAYER_SPEEDUP_EN
  assign fast = (size_q >= 4'd6);
`else
  assign fast = 1'b0;
`endif

  assign size_ok = (sequenceSize != 4'd0) && (sequenceSize <= 4'(MAX_LEN));

  // The length is chosen by the current state; when a transition happens the
  // load pulse restarts the count, so the new state's length applies from its
  // first cycle.
  always_comb begin
    timer_len = fast ? ON_FAST : ON_LEN;
    if (state_q == OFF) timer_len = fast ? OFF_FAST : OFF_LEN;
  end

  interval_timer #(.CNT_W(CNT_W)) u_timer (
    .clock  (CLOCK_50),
    .resetn (resetn),
    .load   (timer_load),
    .length (timer_len),
    .expire (expire)
  );

  always_comb begin
    state_d = state_q;
    seq_d   = seq_q;
    size_d  = size_q;
    index_d = index_q;
    case (state_q)
      IDLE: begin
        if (start && !abort && size_ok) begin
          state_d = ON;
          seq_d   = sequence_bits;
          size_d  = sequenceSize;
          index_d = 4'd0;
        end
      end
      ON: begin
        if (abort)       state_d = IDLE;
        else if (expire) state_d = OFF;
      end
      OFF: begin
        if (abort) begin
          state_d = IDLE;
        end else if (expire) begin
          if (index_q == size_q - 4'd1) begin
            state_d = DONE;
          end else begin
            index_d = index_q + 4'd1;
            state_d = ON;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    timer_load = (state_d != state_q);
    // Lights are computed from the next-state values so the first element
    // shows in the very first ON cycle.
    lights_d = (state_d == ON) ? get_element(seq_d, index_d) : 4'b0000;
  end

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      state_q  <= IDLE;
      seq_q    <= '0;
      size_q   <= 4'd0;
      index_q  <= 4'd0;
      lights_q <= 4'b0000;
    end else begin
      state_q  <= state_d;
      seq_q    <= seq_d;
      size_q   <= size_d;
      index_q  <= index_d;
      lights_q <= lights_d;
    end
  end

  assign lights       = lights_q;
  assign busy         = (state_q != IDLE);
  assign startreading = (state_q == ON) || (state_q == OFF);
  assign done         = (state_q == DONE);

endmodule
